qnigma_alu_seq: RTL and testbench

Microprogram sequencer that drives the ALU task interface (task_info/task_valid/task_done/alu_eql). It fetches instructions from an external program ROM and issues ALU tasks one at a time. It supports counted loops and branches on the ALU equality flag. It sits between the ECC/Poly1305 top-level control and the ALU, so that a complete field routine (ladder step, inversion chain) runs from a single start pulse.

---
 rtl/qnigma_alu_seq_if.sv | 26 ++
 rtl/qnigma_alu_seq.sv | 153 +++++++++++++++
 tb/tb_qnigma_alu_seq.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qnigma_alu_seq_if.sv
// Bundles the sequencer's program-ROM fetch port and its ALU task port.
// The sequencer uses the master modport; the ROM and ALU side use slave.
interface qnigma_alu_seq_if #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned TASK_W = 8
);
  logic              rom_req;
  logic [PC_W-1:0]   rom_addr;
  logic [1:0]        ins_kind;
  logic [PC_W-1:0]   ins_tgt;
  logic [TASK_W-1:0] ins_task;
  logic [TASK_W-1:0] task_info;
  logic              task_valid;
  logic              task_done;
  logic              alu_eql;

  modport master (
    output rom_req, rom_addr, task_info, task_valid,
    input  ins_kind, ins_tgt, ins_task, task_done, alu_eql
  );

  modport slave (
    input  rom_req, rom_addr, task_info, task_valid,
    output ins_kind, ins_tgt, ins_task, task_done, alu_eql
  );
endinterface

// File: rtl/qnigma_alu_seq.sv
// Microprogram sequencer: fetches instructions from a 1-cycle-latency ROM and issues
// ALU tasks one at a time, with counted loops, equality branches and a watchdog.
module qnigma_alu_seq #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TMO_CYC = 4096,
  parameter int unsigned TASK_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  start_pc,
  input  logic [CNT_W-1:0] loop_cnt,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  qnigma_alu_seq_if.master bus
);

  localparam int unsigned WDT_W = $clog2(TMO_CYC);

  typedef enum logic [1:0] {StIdle, StFetch, StDecode, StWait} state_e;
  typedef enum logic [1:0] {InsOp, InsLoop, InsBeq, InsEnd} ins_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              eql_lat_q, eql_lat_d;
  logic [WDT_W-1:0]  wdt_q, wdt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              tvalid_q, tvalid_d;
  logic [TASK_W-1:0] tinfo_q, tinfo_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    eql_lat_d = eql_lat_q;
    wdt_d     = wdt_q;
    busy_d    = busy_q;
    tinfo_d   = tinfo_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tvalid_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          pc_d      = start_pc;
          cnt_d     = loop_cnt;
          eql_lat_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        unique case (ins_e'(bus.ins_kind))
          InsOp: begin
            tinfo_d  = bus.ins_task;
            tvalid_d = 1'b1;
            wdt_d    = '0;
            state_d  = StWait;
          end
          InsLoop: begin
            // A zero counter falls through rather than wrapping
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
              pc_d  = bus.ins_tgt;
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
            state_d = StFetch;
          end
          InsBeq: begin
            pc_d    = eql_lat_q ? bus.ins_tgt : pc_q + PC_W'(1);
            state_d = StFetch;
          end
          InsEnd: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        endcase
      end
      StWait: begin
        wdt_d = wdt_q + WDT_W'(1);
        if (bus.task_done) begin
          eql_lat_d = bus.alu_eql;
          pc_d      = pc_q + PC_W'(1);
          state_d   = StFetch;
        end else if (wdt_q == WDT_W'(TMO_CYC - 1)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort silently drops the program; program state stays as it was
    if (abort && state_q != StIdle) begin
      state_d   = StIdle;
      busy_d    = 1'b0;
      tvalid_d  = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      eql_lat_d = eql_lat_q;
      tinfo_d   = tinfo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      cnt_q     <= '0;
      eql_lat_q <= 1'b0;
      wdt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tvalid_q  <= 1'b0;
      tinfo_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      eql_lat_q <= eql_lat_d;
      wdt_q     <= wdt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tvalid_q  <= tvalid_d;
      tinfo_q   <= tinfo_d;
    end
  end

  assign bus.rom_req    = (state_q == StFetch);
  assign bus.rom_addr   = pc_q;
  assign bus.task_valid = tvalid_q;
  assign bus.task_info  = tinfo_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_qnigma_alu_seq.sv
// Scoreboard bench for qnigma_alu_seq: ROM and ALU models drive the slave side, the
// expected fetch/issue/done trace is queued up front and a monitor checks it in order.
module tb_qnigma_alu_seq;
  localparam int unsigned PC_W = 8, CNT_W = 8, TASK_W = 8, TMO = 16;
  localparam logic [1:0] EvFetch = 2'd0, EvIssue = 2'd1, EvDone = 2'd2;
  localparam logic [1:0] KOp = 2'd0, KLoop = 2'd1, KBeq = 2'd2, KEnd = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] start_pc = 8'h00;
  logic [7:0] loop_cnt = 8'h00;
  logic       busy, done, err;

  qnigma_alu_seq_if #(.PC_W(PC_W), .TASK_W(TASK_W)) bus ();

  qnigma_alu_seq #(.PC_W(PC_W), .CNT_W(CNT_W), .TMO_CYC(TMO), .TASK_W(TASK_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .start_pc (start_pc),
    .loop_cnt (loop_cnt),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_cmp = 0, n_bad = 0;
  ev_t exp_q[$];
  int  start_cyc, first_issue_cyc, issue_cyc, done_cyc;
  bit  first_pend = 0;

  logic [1:0] rom_kind [256];
  logic [7:0] rom_tgt  [256];
  logic [7:0] rom_task [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ev(input logic [1:0] k, input logic [7:0] v);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event at cyc %0d: kind %0d val %0h, nothing expected", cyc, k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.val !== v) begin
        n_bad++;
        $display("FAIL trace_event at cyc %0d: got kind %0d val %0h, expected kind %0d val %0h",
                 cyc, k, v, e.kind, e.val);
      end
    end
  endtask

  function automatic void push(input logic [1:0] k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  function automatic void put(input logic [7:0] a, input logic [1:0] k, input logic [7:0] t,
                              input logic [7:0] tk);
    rom_kind[a] = k;
    rom_tgt[a]  = t;
    rom_task[a] = tk;
  endfunction

  function automatic void exp_prog_a();
    push(EvFetch, 8'h10); push(EvIssue, 8'h0A);
    push(EvFetch, 8'h11); push(EvIssue, 8'h0B);
    push(EvFetch, 8'h12); push(EvDone, 8'h00);
  endfunction

  // Monitor: every fetch, issue and done the DUT presents must match the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rom_req) check_ev(EvFetch, bus.rom_addr);
      if (bus.task_valid) begin
        check_ev(EvIssue, bus.task_info);
        issue_cyc = cyc;
        if (first_pend) begin
          first_issue_cyc = cyc;
          first_pend = 0;
        end
      end
      if (done) begin
        check_ev(EvDone, {7'b0, err});
        done_cyc = cyc;
      end
      if (err && !done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL err_without_done at cyc %0d: err 1, done 0", cyc);
      end
    end
  end

  // ROM model: data for the fetched address appears in the following cycle
  logic [7:0] rom_a;
  initial begin
    bus.ins_kind = KEnd;
    bus.ins_tgt  = 8'h00;
    bus.ins_task = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus.rom_req) begin
        rom_a = bus.rom_addr;
        @(posedge clk); #1;
        bus.ins_kind = rom_kind[rom_a];
        bus.ins_tgt  = rom_tgt[rom_a];
        bus.ins_task = rom_task[rom_a];
      end
    end
  end

  // ALU model: fixed latency, optional mute, optional stray done during a chosen DECODE
  int         alu_lat = 5;
  bit         alu_mute = 0, alu_eql_cfg = 0, stray_arm = 0, stray_next = 0;
  int         alu_cnt = 0;
  logic [7:0] stray_addr = 8'h31;
  initial begin
    bus.task_done = 1'b0;
    bus.alu_eql   = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.task_done = 1'b0;
      if (rst) begin
        alu_cnt    = 0;
        stray_next = 0;
      end
      if (stray_next) begin
        bus.task_done = 1'b1;
        bus.alu_eql   = 1'b1;
        stray_next    = 0;
      end
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          bus.task_done = 1'b1;
          bus.alu_eql   = alu_eql_cfg;
        end
      end
      if (stray_arm && bus.rom_req && bus.rom_addr == stray_addr) stray_next = 1;
      if (bus.task_valid && !alu_mute) alu_cnt = alu_lat;
    end
  end

  task automatic start_prog(input logic [7:0] pc, input logic [7:0] cnt);
    @(negedge clk);
    start_pc   = pc;
    loop_cnt   = cnt;
    start      = 1'b1;
    start_cyc  = cyc;
    first_pend = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    bit low = 0;
    do begin
      @(negedge clk);
      n++;
      if (done) break;
      if (!busy) low = 1;
    end while (n < budget);
    #1;
    chk({name, "_done_seen"}, done, 1);
    chk({name, "_busy_held"}, low, 0);
    chk({name, "_busy_at_done"}, busy, 0);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    for (int i = 0; i < 256; i++) put(i[7:0], KEnd, 8'h00, 8'h00);
    put(8'h10, KOp, 8'h00, 8'h0A); put(8'h11, KOp, 8'h00, 8'h0B); put(8'h12, KEnd, 8'h00, 8'h00);
    put(8'h00, KOp, 8'h00, 8'h21); put(8'h01, KLoop, 8'h00, 8'h00);
    put(8'h30, KOp, 8'h00, 8'h31); put(8'h31, KBeq, 8'h20, 8'h00);
    put(8'h40, KOp, 8'h00, 8'h41);
    put(8'hFF, KOp, 8'h00, 8'h55);
    put(8'h50, KOp, 8'h00, 8'h66);

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, err, bus.rom_req, bus.rom_addr, bus.task_valid,
                          bus.task_info}, 0);
    rst = 1'b0;

    // Two OPs then END; a start pulse during DECODE must be ignored
    exp_prog_a();
    start_prog(8'h10, 8'h00);
    @(negedge clk);
    start_pc = 8'h00;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("prog_a", 200);
    chk("start_to_issue", first_issue_cyc - start_cyc, 3);

    // Counted loop with loop_cnt=3: four issues
    for (int i = 0; i < 4; i++) begin
      push(EvFetch, 8'h00); push(EvIssue, 8'h21); push(EvFetch, 8'h01);
    end
    push(EvFetch, 8'h02); push(EvDone, 8'h00);
    start_prog(8'h00, 8'h03);
    wait_done("loop", 400);
    chk("loop_cnt_end", dut.cnt_q, 0);

    // Branch taken on eql=1
    alu_eql_cfg = 1;
    push(EvFetch, 8'h30); push(EvIssue, 8'h31); push(EvFetch, 8'h31);
    push(EvFetch, 8'h20); push(EvDone, 8'h00);
    start_prog(8'h30, 8'h00);
    wait_done("beq_taken", 200);

    // Branch not taken on eql=0, with a stray eql=1 done during DECODE
    alu_eql_cfg = 0;
    stray_arm   = 1;
    push(EvFetch, 8'h30); push(EvIssue, 8'h31); push(EvFetch, 8'h31);
    push(EvFetch, 8'h32); push(EvDone, 8'h00);
    start_prog(8'h30, 8'h00);
    wait_done("beq_not_taken", 200);
    stray_arm = 0;

    // Watchdog: ALU never answers
    alu_mute = 1;
    push(EvFetch, 8'h40); push(EvIssue, 8'h41); push(EvDone, 8'h01);
    start_prog(8'h40, 8'h00);
    wait_done("watchdog", 100);
    chk("wdt_latency", done_cyc - issue_cyc, TMO);
    alu_mute = 0;
    @(negedge clk);
    chk("wdt_single_pulse", {done, err}, 0);
    exp_prog_a();
    start_prog(8'h10, 8'h00);
    wait_done("after_wdt", 200);

    // PC wrap from 0xFF to 0x00
    push(EvFetch, 8'hFF); push(EvIssue, 8'h55); push(EvFetch, 8'h00); push(EvIssue, 8'h21);
    push(EvFetch, 8'h01); push(EvFetch, 8'h02); push(EvDone, 8'h00);
    start_prog(8'hFF, 8'h00);
    wait_done("wrap", 300);

    // Abort in WAIT; the ALU still answers 3 cycles later
    alu_lat = 4;
    push(EvFetch, 8'h50); push(EvIssue, 8'h66);
    start_prog(8'h50, 8'h00);
    n = 0;
    while (!bus.task_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_issue_seen", bus.task_valid, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {busy, bus.task_valid, done, err}, 0);
    repeat (8) @(negedge clk);
    #1;
    chk("abort_queue", exp_q.size(), 0);
    chk("abort_pc_kept", dut.pc_q, 8'h50);
    chk("abort_busy_low", busy, 0);
    alu_lat = 5;

    // Abort and start together in IDLE: start dropped
    @(negedge clk);
    start_pc = 8'h10;
    start    = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    seen  = 0;
    repeat (4) begin
      if (busy) seen = 1;
      @(negedge clk);
    end
    chk("abort_beats_start", seen, 0);

    // Reset during FETCH clears everything on the next cycle
    push(EvFetch, 8'h10);
    start_prog(8'h10, 8'h05);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_fetch", {busy, done, err, bus.rom_req, bus.rom_addr, bus.task_valid,
                            bus.task_info}, 0);
    chk("reset_pc_cnt", {dut.pc_q, dut.cnt_q}, 0);
    chk("reset_queue", exp_q.size(), 0);
    rst = 1'b0;
    exp_prog_a();
    start_prog(8'h10, 8'h00);
    wait_done("after_reset", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
